// File: rtl/pll_reset_ctrl.sv
// PLL control and reset sequencer: drives altpll areset/clkena, qualifies lock,
// and holds the system in reset until lock has stayed up for a full window.
module pll_reset_ctrl #(
   parameter int NUM_CLKS      = 3,
   parameter int LOCK_CNT_W    = 6,
   parameter int ARESET_CYCLES = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          address,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [15:0]         writedata,
   output logic [15:0]         readdata,
   input  logic                pll_locked,
   output logic                pll_areset,
   output logic [NUM_CLKS-1:0] clkena,
   output logic                resetrequest
);

   typedef enum logic [1:0] {
      ST_ARESET    = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam logic [7:0] ARESET_LAST = 8'(ARESET_CYCLES - 1);

   state_t                state, state_nxt;
   logic [7:0]            areset_cnt, areset_cnt_nxt;
   logic [LOCK_CNT_W-1:0] stab_cnt, stab_cnt_nxt;
   logic                  lock_m, lock_s;
   logic                  lock_lost;
   logic [7:0]            loss_cnt, loss_base;
   logic [NUM_CLKS-1:0]   clkena_mask, clkena_r;
   logic                  loss_event;
   logic                  wr_en, sw_areset, mask_wr, clr_wr;
   logic                  unused;

   // The read strobe is irrelevant because reads are purely combinational.
   assign unused = &{1'b0, read, writedata};

   assign wr_en     = chipselect & write;
   assign mask_wr   = wr_en & (address == 3'd1);
   assign sw_areset = mask_wr & writedata[0];
   assign clr_wr    = wr_en & (address == 3'd2) & writedata[0];

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt      = state;
      areset_cnt_nxt = areset_cnt;
      stab_cnt_nxt   = stab_cnt;
      loss_event     = 1'b0;
      if (sw_areset) begin
         state_nxt      = ST_ARESET;
         areset_cnt_nxt = '0;
      end else begin
         case (state)
            ST_ARESET: begin
               if (areset_cnt == ARESET_LAST) begin
                  state_nxt      = ST_WAIT_LOCK;
                  areset_cnt_nxt = '0;
               end else begin
                  areset_cnt_nxt = areset_cnt + 8'd1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt    = ST_STABLE;
                  stab_cnt_nxt = '0;
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_nxt    = ST_WAIT_LOCK;
                  stab_cnt_nxt = '0;
               end else if (&stab_cnt) begin
                  state_nxt = ST_RUN;
               end else begin
                  stab_cnt_nxt = stab_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_nxt  = ST_WAIT_LOCK;
                  loss_event = 1'b1;
               end
            end
            default: state_nxt = ST_ARESET;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_ARESET;
         areset_cnt <= '0;
         stab_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         areset_cnt <= areset_cnt_nxt;
         stab_cnt   <= stab_cnt_nxt;
      end
   end

   // A clear landing on the same edge as a loss is applied first, so the loss survives.
   assign loss_base = clr_wr ? 8'd0 : loss_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_lost <= 1'b0;
         loss_cnt  <= '0;
      end else if (loss_event) begin
         lock_lost <= 1'b1;
         loss_cnt  <= (loss_base == 8'hFF) ? 8'hFF : loss_base + 8'd1;
      end else if (clr_wr) begin
         lock_lost <= 1'b0;
         loss_cnt  <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clkena_mask <= '1;
         clkena_r    <= '0;
      end else begin
         if (mask_wr) clkena_mask <= writedata[8 +: NUM_CLKS];
         clkena_r <= clkena_mask;
      end
   end

   assign pll_areset   = (state == ST_ARESET);
   assign resetrequest = (state != ST_RUN);
   assign clkena       = (state == ST_RUN) ? clkena_r : '0;

   always_comb begin
      readdata = '0;
      case (address)
         3'd0:    readdata = {loss_cnt, 3'b000, state, lock_lost, state == ST_RUN, lock_s};
         3'd1:    readdata[8 +: NUM_CLKS] = clkena_mask;
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: stimulus queues expectations, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_pll_reset_ctrl;

   typedef struct {
      string       name;
      int          sel;   // 0 readdata, 1 pll_areset, 2 resetrequest, 3 clkena
      logic [15:0] val;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect, read, write;
   logic [15:0] writedata, readdata;
   logic        pll_locked, pll_areset, resetrequest;
   logic [2:0]  clkena;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [15:0] act;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          w, c, m;

   pll_reset_ctrl #(.NUM_CLKS(3), .LOCK_CNT_W(4), .ARESET_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read(read), .write(write), .writedata(writedata), .readdata(readdata),
      .pll_locked(pll_locked), .pll_areset(pll_areset), .clkena(clkena),
      .resetrequest(resetrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      while (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         case (cur.sel)
            0:       act = readdata;
            1:       act = {15'd0, pll_areset};
            2:       act = {15'd0, resetrequest};
            default: act = {13'd0, clkena};
         endcase
         n_cmp++;
         if (act !== cur.val) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", cur.name, act, cur.val, cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic expect_val(input string nm, input int sel, input logic [15:0] v);
      exp_t e;
      e.name = nm;
      e.sel  = sel;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_rd(input string nm, input logic [2:0] a, input logic [15:0] v);
      address = a;
      read    = 1'b1;
      expect_val(nm, 0, v);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      read       = 1'b0;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = 16'd0;
   endtask

   // Drop lock in RUN, relock once the FSM has left RUN, return when RUN is re-entered.
   task automatic loss_cycle();
      int c0;
      c0 = cyc;
      pll_locked = 1'b0;
      goto_cyc(c0 + 3);
      pll_locked = 1'b1;
      goto_cyc(c0 + 22);
   endtask

   initial begin
      reset_n    = 1'b0;
      pll_locked = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      expect_val("rst_areset", 1, 16'd1);
      expect_val("rst_rr", 2, 16'd1);
      expect_val("rst_clkena", 3, 16'd0);
      expect_rd("rst_status", 3'd0, 16'h0000);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc     = 0;

      // Power-up: areset for 8 edges, lock_s up at edge 2, RUN at edge 25.
      for (int k = 1; k <= 8; k++) begin
         goto_cyc(k);
         expect_val("pwr_areset", 1, (k < 8) ? 16'd1 : 16'd0);
      end
      goto_cyc(24);
      expect_val("pwr_rr_before", 2, 16'd1);
      goto_cyc(25);
      expect_val("pwr_rr", 2, 16'd0);
      expect_val("pwr_clkena", 3, 16'h0007);
      expect_rd("pwr_status", 3'd0, 16'h001B);

      // Glitch during STABLE: re-enter through software areset, keeping the mask.
      tick();
      wr(3'd1, 16'h0701);
      w = cyc;
      goto_cyc(w + 19);
      expect_rd("stable_status", 3'd0, 16'h0011);
      pll_locked = 1'b0;
      goto_cyc(w + 22);
      pll_locked = 1'b1;
      expect_rd("glitch_wait", 3'd0, 16'h0008);
      goto_cyc(w + 40);
      expect_val("glitch_rr_before", 2, 16'd1);
      goto_cyc(w + 41);
      expect_val("glitch_rr", 2, 16'd0);
      expect_rd("glitch_status", 3'd0, 16'h001B);

      // Lock loss in RUN.
      tick();
      c = cyc;
      pll_locked = 1'b0;
      goto_cyc(c + 3);
      expect_val("loss_rr", 2, 16'd1);
      expect_val("loss_clkena", 3, 16'd0);
      expect_rd("loss_status", 3'd0, 16'h010C);
      pll_locked = 1'b1;
      goto_cyc(c + 21);
      expect_val("relock_rr_before", 2, 16'd1);
      goto_cyc(c + 22);
      expect_val("relock_rr", 2, 16'd0);
      expect_rd("relock_status", 3'd0, 16'h011F);

      // Software areset in RUN; writing 0x0001 also zeroes the mask.
      tick();
      wr(3'd1, 16'h0001);
      w = cyc;
      for (int k = 0; k <= 8; k++) begin
         goto_cyc(w + k);
         expect_val("sw_areset", 1, (k < 8) ? 16'd1 : 16'd0);
         expect_val("sw_rr", 2, 16'd1);
         if (k == 1) expect_rd("sw_status", 3'd0, 16'h0105);
         if (k == 2) expect_rd("sw_ctrl_rd", 3'd1, 16'h0000);
      end
      goto_cyc(w + 24);
      expect_val("sw_rr_before", 2, 16'd1);
      goto_cyc(w + 25);
      expect_val("sw_rr_run", 2, 16'd0);
      expect_val("sw_clkena_masked", 3, 16'd0);
      expect_rd("sw_run_status", 3'd0, 16'h011F);

      tick();
      wr(3'd2, 16'h0001);
      expect_rd("clear_status", 3'd0, 16'h001B);

      // Mask write in RUN, then survive a loss and recovery.
      tick();
      wr(3'd1, 16'h0500);
      m = cyc;
      goto_cyc(m + 1);
      expect_val("mask_clkena", 3, 16'h0005);
      expect_rd("mask_ctrl_rd", 3'd1, 16'h0500);
      tick();
      c = cyc;
      pll_locked = 1'b0;
      goto_cyc(c + 3);
      expect_val("mask_loss_clkena", 3, 16'd0);
      pll_locked = 1'b1;
      goto_cyc(c + 22);
      expect_val("mask_relock_clkena", 3, 16'h0005);
      expect_rd("mask_relock_status", 3'd0, 16'h011F);

      // Saturation: loss_cnt starts at 1, each cycle adds one, capped at 255.
      for (int i = 0; i < 260; i++) begin
         loss_cycle();
         if (i == 198) expect_rd("sat_mid_status", 3'd0, 16'hC81F);
      end
      expect_rd("sat_status", 3'd0, 16'hFF1F);

      // Clear write on the same edge the FSM registers a loss.
      tick();
      c = cyc;
      pll_locked = 1'b0;
      goto_cyc(c + 2);
      wr(3'd2, 16'h0001);
      expect_rd("collide_status", 3'd0, 16'h010C);
      pll_locked = 1'b1;
      goto_cyc(c + 22);
      expect_rd("collide_relock", 3'd0, 16'h011F);

      // Asynchronous reset in RUN: observed before any further clock edge.
      tick();
      reset_n = 1'b0;
      expect_val("arst_areset", 1, 16'd1);
      expect_val("arst_rr", 2, 16'd1);
      expect_val("arst_clkena", 3, 16'd0);
      expect_rd("arst_status", 3'd0, 16'h0000);
      tick();
      expect_rd("arst_mask", 3'd1, 16'h0700);
      tick();
      reset_n = 1'b1;
      tick();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
